// File: rtl/dtc_pkg.sv
// Shared types and constants for the DTC edge generator.
package dtc_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, PULSE} dtc_state_e;

  // Fibonacci taps 16,14,13,11 (1-based), as a bit mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Offset that maps a two's-complement code onto an unsigned delay
  function automatic int code_offset(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/dtc_lfsr.sv
// 16-bit Fibonacci LFSR supplying one dither bit per accepted reference edge.
module dtc_lfsr
  import dtc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic dbit
);

  logic [15:0] q;

  // Shift left, feedback from the XOR of the tapped bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

  assign dbit = q[0];

endmodule

// File: rtl/dtc_edge_gen.sv
// Digital-to-time converter: turns a signed phase code into a feedback pulse
// delayed from ref_edge by (code + 2^(DOUT_WIDTH-1)) clk ticks.
// Optional dither: define DTC_DITHER_EN to add an LFSR LSB to each delay.
module dtc_edge_gen
  import dtc_pkg::*;
#(
  parameter int          DOUT_WIDTH = 7,
  parameter int          PULSE_W    = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DOUT_WIDTH-1:0] code,
  input  logic                         code_valid,
  output logic                         code_ready,
  input  logic                         ref_edge,
  output logic                         fb_out,
  output logic                         busy,
  output logic                         overrun,
  output logic        [DOUT_WIDTH-1:0] delay_q
);

  localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [DOUT_WIDTH-1:0] OFFSET = DOUT_WIDTH'(code_offset(DOUT_WIDTH));

  dtc_state_e            state;
  logic [DOUT_WIDTH-1:0] hold_code, cur_code, cnt, base, dly;
  logic [DOUT_WIDTH:0]   dsum;
  logic [PW-1:0]         pcnt;
  logic                  full, fire, dith;

  assign fire       = ref_edge && (state == IDLE);
  assign code_ready = !full;

  // A held code takes effect on the edge that consumes it
  assign base = (full ? hold_code : cur_code) + OFFSET;

`ifdef DTC_DITHER_EN
  dtc_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (fire),
    .dbit (dith)
  );
`else
  // Without dither the seed plays no part; the dither bit is tied low
  assign dith = LFSR_SEED[0] & 1'b0;
`endif

  // Saturating add of the dither bit; exact mapping when dith is 0
  assign dsum = {1'b0, base} + {{DOUT_WIDTH{1'b0}}, dith};
  assign dly  = dsum[DOUT_WIDTH] ? '1 : dsum[DOUT_WIDTH-1:0];

  // One-entry holding register; accept and consume never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_code <= '0;
      full      <= 1'b0;
    end else if (code_valid && !full) begin
      hold_code <= code;
      full      <= 1'b1;
    end else if (fire && full) begin
      full      <= 1'b0;
    end
  end

  // Main FSM: load delay on ref_edge, count down, then emit PULSE_W-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      fb_out   <= 1'b0;
      overrun  <= 1'b0;
      cnt      <= '0;
      pcnt     <= '0;
      delay_q  <= '0;
      cur_code <= '0;
    end else begin
      overrun <= ref_edge && (state != IDLE);
      case (state)
        IDLE: if (ref_edge) begin
          if (full) cur_code <= hold_code;
          cnt     <= dly;
          delay_q <= dly;
          state   <= COUNT;
          busy    <= 1'b1;
        end
        COUNT: if (cnt == '0) begin
          fb_out <= 1'b1;
          pcnt   <= PW'(PULSE_W - 1);
          state  <= PULSE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        PULSE: if (pcnt == '0) begin
          fb_out <= 1'b0;
          state  <= IDLE;
          busy   <= 1'b0;
        end else begin
          pcnt <= pcnt - 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          fb_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_edge_gen.sv
// Directed self-checking bench for dtc_edge_gen.
module tb_dtc_edge_gen;

  localparam int W  = 7;
  localparam int PW = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, rst_n = 1'b0, code_valid = 1'b0, ref_edge = 1'b0;
  logic signed [W-1:0] code = '0;
  logic code_ready, fb_out, busy, overrun;
  logic [W-1:0] delay_q;

  int n_tests = 0, n_fail = 0;
  logic [15:0] lfsr_m = SEED;
  int d, rise, wid, k, highs;

  always #5 clk = ~clk;

  dtc_edge_gen #(.DOUT_WIDTH(W), .PULSE_W(PW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .ref_edge(ref_edge), .fb_out(fb_out),
    .busy(busy), .overrun(overrun), .delay_q(delay_q)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected delay for a code; advances the dither model when enabled
  task automatic model_dly(input int c, output int dl);
    dl = c + 64;
`ifdef DTC_DITHER_EN
    dl = dl + int'(lfsr_m[0]);
    if (dl > 127) dl = 127;
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
  endtask

  task automatic send_code(input int c);
    code = W'(c);
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  task automatic fire(input int c, output int dl);
    model_dly(c, dl);
    ref_edge = 1'b1;
    step();
    ref_edge = 1'b0;
  endtask

  // k0 = offset of the current cycle from the ref_edge cycle
  task automatic measure(input int k0, output int r, output int w);
    int kk;
    kk = k0;
    while (!fb_out && kk < 400) begin step(); kk++; end
    r = kk;
    w = 0;
    while (fb_out && w < 20) begin w++; step(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_fb", fb_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ready", code_ready, 1);
    chk("rst_dq", delay_q, 0);
    rst_n = 1'b1;
    step();

    // Zero code: delay 64, pulse 2 cycles after 2+64
    send_code(0);
    chk("ready_low", code_ready, 0);
    fire(0, d);
    chk("z_dq", delay_q, d);
    chk("z_busy", busy, 1);
    chk("z_ready", code_ready, 1);
    measure(1, rise, wid);
    chk("z_rise", rise, 2 + d);
    chk("z_wid", wid, PW);
    chk("z_idle", busy, 0);

    // Extremes
    send_code(-64);
    fire(-64, d);
    chk("min_dq", delay_q, d);
    measure(1, rise, wid);
    chk("min_rise", rise, 2 + d);
    chk("min_wid", wid, PW);
    send_code(63);
    fire(63, d);
    chk("max_dq", delay_q, d);
    measure(1, rise, wid);
    chk("max_rise", rise, 2 + d);
    chk("max_wid", wid, PW);

    // Dropped edge during COUNT
    send_code(10);
    fire(10, d);
    repeat (5) step();
    ref_edge = 1'b1;
    step();
    ref_edge = 1'b0;
    chk("ovr_pulse", overrun, 1);
    step();
    chk("ovr_clear", overrun, 0);
    chk("ovr_busy", busy, 1);
    measure(8, rise, wid);
    chk("ovr_rise", rise, 2 + d);
    chk("ovr_wid", wid, PW);
    highs = 0;
    repeat (10) begin if (fb_out) highs++; step(); end
    chk("ovr_nopulse", highs, 0);

    // Offer while full is refused
    send_code(3);
    code = W'(20);
    code_valid = 1'b1;
    chk("full_ready", code_ready, 0);
    step();
    code_valid = 1'b0;
    fire(3, d);
    chk("full_dq", delay_q, d);
    measure(1, rise, wid);
    chk("full_rise", rise, 2 + d);
    // Reuse of last code (20 was never taken)
    fire(3, d);
    chk("reuse_dq", delay_q, d);
    measure(1, rise, wid);
    chk("reuse_rise", rise, 2 + d);

    // Same-cycle accept + ref_edge: old code now, new code next
    code = W'(5);
    code_valid = 1'b1;
    model_dly(3, d);
    ref_edge = 1'b1;
    step();
    ref_edge = 1'b0;
    code_valid = 1'b0;
    chk("sim_dq", delay_q, d);
    chk("sim_held", code_ready, 0);
    measure(1, rise, wid);
    chk("sim_rise", rise, 2 + d);
    fire(5, d);
    chk("sim_next_dq", delay_q, d);
    measure(1, rise, wid);
    chk("sim_next_rise", rise, 2 + d);

    // Reset while counting with cnt = 30; held code 40 is discarded
    send_code(0);
    fire(0, d);
    step(); step();
    send_code(40);
    chk("mr_held", code_ready, 0);
    k = 4;
    while (k < 64 + 1 - 30) begin step(); k++; end
    chk("mr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_fb", fb_out, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_ready", code_ready, 1);
    lfsr_m = SEED;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    fire(0, d);
    chk("mr_dq", delay_q, d);
    measure(1, rise, wid);
    chk("mr_rise", rise, 2 + d);

`ifdef DTC_DITHER_EN
    // Dither: saturation at 127 and LSB sequence from the seed
    send_code(63);
    repeat (6) begin
      fire(63, d);
      chk("dith_sat", delay_q, 127);
      measure(1, rise, wid);
    end
    send_code(0);
    repeat (6) begin
      fire(0, d);
      chk("dith_seq", delay_q, d);
      measure(1, rise, wid);
      chk("dith_rise", rise, 2 + d);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtc_edge_gen.md
Name: dtc_edge_gen

Overview:
- Digital-to-time converter: the inverse of the PLL's time-to-digital path.
- Takes a signed phase code, the same format the TDC emits (DOUT_WIDTH bits, two's complement).
- Emits a feedback edge delayed from a reference event by a code-dependent number of fast-clock ticks.
- Sits between the loop filter / digital correction and the feedback input of the TDC in closed-loop PLL benches; one tick represents one TDC LSB.

Parameters:
- DOUT_WIDTH, 7, code width; must match the TDC output width.
- PULSE_W, 2, fb_out high time in clk cycles (>=1).
- LFSR_SEED, 16'hACE1, dither LFSR reset value (used only with the optional feature).

Ports:
- clk  input  1  fast tick clock; one period = one code LSB.
- rst_n  input  1  asynchronous active-low reset.
- code  input  DOUT_WIDTH  signed phase code.
- code_valid  input  1  code is offered this cycle.
- code_ready  output  1  holding register empty; code accepted on valid && ready.
- ref_edge  input  1  single-cycle synchronous pulse marking the reference event.
- fb_out  output  1  generated feedback pulse.
- busy  output  1  high in COUNT or PULSE.
- overrun  output  1  one-cycle pulse when a ref_edge is dropped.
- delay_q  output  DOUT_WIDTH  unsigned delay currently or last loaded.

Behaviour:
- Reset (async assert, sync release): every output is 0 except code_ready, which is 1. State is IDLE, holding register empty, cur_code = 0.
- Code path:
  - code is captured into a one-entry holding register on code_valid && code_ready.
  - code_ready falls the next cycle and stays low until the register is consumed.
- Delay mapping: delay = code + 2^(DOUT_WIDTH-1), computed unsigned, width DOUT_WIDTH. For the default width, -64 maps to 0, 0 maps to 64 and 63 maps to 127. There is no overflow by construction.
- State IDLE, ref_edge in cycle t:
  - If the holding register is full, its code becomes cur_code and the register empties; code_ready is 1 at t+1.
  - Otherwise cur_code is reused.
  - cnt and delay_q are loaded with the delay of cur_code. Next state is COUNT.
- State COUNT: if cnt == 0, set fb_out = 1 and go to PULSE with pcnt = PULSE_W-1; else decrement cnt.
- State PULSE: fb_out held high. If pcnt == 0, fb_out = 0 and go to IDLE; else decrement pcnt.
- Latency: fb_out rises in cycle t + 2 + delay and stays high exactly PULSE_W cycles.
- Drop rule: a ref_edge in COUNT or PULSE is ignored. overrun pulses one cycle later and the state is unaffected.
- Simultaneous events:
  - code accept and ref_edge in the same IDLE cycle: ref_edge uses the previously held/current code; the new code is held for the next event.
  - A code offered while the register is full is simply not accepted (ready low).
- Reset mid-operation: immediate return to IDLE. fb_out drops asynchronously and the held code is discarded.
- busy = (state != IDLE), registered alongside the state.

Optional Feature:
- Macro DTC_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seeded LFSR_SEED on reset) advances on each ref_edge accepted in IDLE.
  - Its LSB is added to delay, saturating at 2^DOUT_WIDTH-1.
  - delay_q reports the dithered value.
- Undefined: no LFSR logic, and delay is exactly as mapped above.

Decomposition:
- Package dtc_pkg holds:
  - the state enum (IDLE, COUNT, PULSE);
  - a localparam function for the code offset 2^(DOUT_WIDTH-1);
  - the LFSR tap constant.
- One sub-module: dtc_lfsr (16-bit, enable, seed), instantiated only under DTC_DITHER_EN.

Test Plan:
- Pulse timing at zero code: reset, accept code=0, ref_edge at cycle 10 -> delay_q=64; fb_out high cycles 76..77; busy high cycles 11..77.
- Delay extremes: code=-64 then ref_edge at cycle t -> fb_out rises t+2. code=63 -> fb_out rises t+129. PULSE_W=2 both times.
- Dropped edges and code handshake:
  - A second ref_edge during COUNT -> overrun one cycle later, no extra fb_out pulse.
  - A code offered while the register is full -> code_ready=0, code not taken.
- Code reuse and same-cycle accept: with no new code, a second ref_edge reuses the last code (same delay_q). Simultaneous accept(code=5)+ref_edge -> the old code is used, and code 5 is used on the next event.
- Reset mid-count: rst_n low during COUNT with cnt=30 -> fb_out=0, busy=0, code_ready=1 immediately. The next ref_edge uses cur_code=0 (delay 64).
- Dither (with DTC_DITHER_EN):
  - code=63 repeatedly -> delay_q never exceeds 127.
  - code=0 -> delay_q is 64 or 65 following the LFSR LSB sequence from 16'hACE1.
